icache: RTL

ICACHE -- requirements
Module: icache

---
 rtl/icache_if.sv | 25 ++
 rtl/icache.sv | 91 +++++++++
 2 files changed

// File: rtl/icache_if.sv
// rtl/icache_if.sv - datapath and memory-side signal bundle for the instruction cache
interface icache_if;
  logic        halt;
  logic        flush;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  modport master (
    output halt, flush, imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr, hit_count, miss_count
  );

  modport slave (
    input  halt, flush, imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr, hit_count, miss_count
  );
endinterface

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped 16-frame one-word instruction cache
// Hits are combinational in IDLE; misses go through a single FETCH state.
module icache (
  input  logic      CLK,
  input  logic      RST,
  icache_if.slave   bus
);
  typedef enum logic {IDLE, FETCH} state_e;

  state_e      state_q, state_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [15:0] valid_q;
  logic [25:0] tag_q  [16];
  logic [31:0] data_q [16];
  logic [31:0] hit_count_q, miss_count_q;
  logic [3:0]  idx, fill_idx;
  logic        hit, fill, iren, fetching;
  logic [31:0] iaddr;

  assign idx      = bus.imemaddr[5:2];
  assign fill_idx = req_addr_q[5:2];

  always_comb begin
    hit = 1'b0;
    if (state_q == IDLE && bus.imemREN && !bus.halt && !bus.flush)
      hit = valid_q[idx] && (tag_q[idx] == bus.imemaddr[31:6]);
  end

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    fill       = 1'b0;
    iren       = 1'b0;
    iaddr      = '0;
    fetching   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.imemREN && !bus.halt && !bus.flush && !hit) begin
          state_d    = FETCH;
          req_addr_d = bus.imemaddr;
        end
      end
      FETCH: begin
        fetching = 1'b1;
        iaddr    = req_addr_q;
        // halt withdraws the memory request in the same cycle
        iren     = !bus.halt;
        fill     = !bus.halt && !bus.iwait;
        if (bus.halt || bus.flush || !bus.iwait)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ihit       = hit;
  assign bus.imemload   = hit ? data_q[idx] : '0;
  assign bus.iREN       = iren;
  assign bus.iaddr      = fetching ? iaddr : '0;
  assign bus.hit_count  = hit_count_q;
  assign bus.miss_count = miss_count_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      req_addr_q   <= '0;
      valid_q      <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      if (hit)
        hit_count_q <= hit_count_q + 32'd1;
      // a fill colliding with flush still counts as a miss but leaves the frame invalid
      if (fill)
        miss_count_q <= miss_count_q + 32'd1;
      if (bus.flush)
        valid_q <= '0;
      else if (fill)
        valid_q[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (fill) begin
      tag_q[fill_idx]  <= req_addr_q[31:6];
      data_q[fill_idx] <= bus.iload;
    end
  end
endmodule
